// File: rtl/cache_pkg.sv
// Shared types for the PLRU cache array: request opcodes, flush sequencer states
// and a parameter bundle used by the controller that sits above this block.
package cache_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_FILL  = 2'd2,
    OP_INVAL = 2'd3
  } op_e;

  typedef enum logic {
    FL_IDLE  = 1'b0,
    FL_FLUSH = 1'b1
  } flush_state_e;

  typedef struct packed {
    logic [7:0] addr_size;
    logic [7:0] num_sets;
    logic [7:0] num_ways;
    logic [7:0] words_per_block;
  } cache_params_t;

  function automatic int tag_bits(int addr_size, int num_sets, int words_per_block);
    return addr_size - $clog2(num_sets) - $clog2(words_per_block) - 2;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: node 1 is the root, node n has children 2n and 2n+1,
// a bit of 0 steers the victim left. Accessing a way turns every node on its path away from it.
module plru_tree #(
  parameter  int NUM_WAYS = 2,
  localparam int WaySize  = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:1] tree_bits,
  input  logic [WaySize-1:0]  access_way,
  output logic [NUM_WAYS-1:1] next_bits,
  output logic [WaySize-1:0]  victim_way
);

  logic [WaySize:0] upd_node;
  logic [WaySize:0] vic_node;

  always_comb begin
    next_bits = tree_bits;
    upd_node  = (WaySize+1)'(1);
    vic_node  = (WaySize+1)'(1);
    for (int l = 0; l < WaySize; l++) begin
      next_bits[upd_node[WaySize-1:0]] = ~access_way[WaySize-1-l];
      upd_node = {upd_node[WaySize-1:0], access_way[WaySize-1-l]};
      vic_node = {vic_node[WaySize-1:0], tree_bits[vic_node[WaySize-1:0]]};
    end
    victim_way = vic_node[WaySize-1:0];
  end

endmodule

// File: rtl/cache_array_plru.sv
// N-way set-associative cache storage with per-byte writes, dirty bits, tree PLRU
// replacement and a one-set-per-cycle invalidate-all sequencer.
module cache_array_plru
  import cache_pkg::*;
#(
  parameter  int ADDR_SIZE       = 32,
  parameter  int NUM_SETS        = 4,
  parameter  int NUM_WAYS        = 2,
  parameter  int WORDS_PER_BLOCK = 1,
  localparam int SetSize   = $clog2(NUM_SETS),
  localparam int WaySize   = $clog2(NUM_WAYS),
  localparam int OffSize   = $clog2(WORDS_PER_BLOCK),
  localparam int OffW      = (OffSize > 0) ? OffSize : 1,
  localparam int TagSize   = tag_bits(ADDR_SIZE, NUM_SETS, WORDS_PER_BLOCK),
  localparam int BlockBits = 32 * WORDS_PER_BLOCK
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           op,
  input  logic [SetSize-1:0]   set,
  input  logic [TagSize-1:0]   tag,
  input  logic [OffW-1:0]      offset,
  input  logic [WaySize-1:0]   way,
  input  logic [3:0]           byte_en,
  input  logic [31:0]          write_data,
  input  logic [BlockBits-1:0] fill_data,
  output logic [NUM_WAYS-1:0]  hits,
  output logic [NUM_WAYS-1:0]  valid_flags,
  output logic [WaySize-1:0]   victim_way,
  output logic                 victim_dirty,
  output logic [TagSize-1:0]   victim_tag,
  output logic [BlockBits-1:0] victim_data,
  output logic [31:0]          read_data,
  output logic                 rd_valid,
  input  logic                 flush_start,
  output logic                 busy
);

  typedef logic [WORDS_PER_BLOCK-1:0][31:0] block_t;

  op_e                 req_op;
  flush_state_e        state_q, state_d;
  logic [SetSize-1:0]  flush_set_q, flush_set_d;
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_d [NUM_SETS];
  logic [NUM_WAYS-1:1] plru_q  [NUM_SETS];
  logic [NUM_WAYS-1:1] plru_d  [NUM_SETS];
  logic [TagSize-1:0]  tag_q   [NUM_SETS][NUM_WAYS];
  logic [TagSize-1:0]  tag_d   [NUM_SETS][NUM_WAYS];
  block_t              data_q  [NUM_SETS][NUM_WAYS];
  block_t              data_d  [NUM_SETS][NUM_WAYS];
  logic [31:0]         read_data_q, read_data_d;
  logic                rd_valid_q, rd_valid_d;

  logic                fire, any_hit, has_invalid;
  logic [WaySize-1:0]  hit_way, inv_way, tree_victim, acc_way;
  logic [NUM_WAYS-1:1] plru_next;
  logic [OffW-1:0]     word_idx;

  assign req_op    = op_e'(op);
  assign busy      = (state_q == FL_FLUSH);
  assign req_ready = ~busy & ~flush_start;
  assign fire      = req_valid & req_ready;
  assign word_idx  = (WORDS_PER_BLOCK > 1) ? offset : '0;

  // Scanning downward leaves the lowest matching / lowest invalid way in the encoders.
  always_comb begin
    hits        = '0;
    hit_way     = '0;
    inv_way     = '0;
    has_invalid = 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[set][w] && (tag_q[set][w] == tag)) begin
        hits[w] = 1'b1;
        hit_way = WaySize'(w);
      end
      if (!valid_q[set][w]) begin
        has_invalid = 1'b1;
        inv_way     = WaySize'(w);
      end
    end
  end

  assign any_hit      = |hits;
  assign valid_flags  = valid_q[set];
  assign victim_way   = has_invalid ? inv_way : tree_victim;
  assign victim_dirty = dirty_q[set][victim_way];
  assign victim_tag   = tag_q[set][victim_way];
  assign victim_data  = data_q[set][victim_way];
  assign acc_way      = (req_op == OP_FILL) ? way : hit_way;
  assign read_data    = read_data_q;
  assign rd_valid     = rd_valid_q;

  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .tree_bits  (plru_q[set]),
    .access_way (acc_way),
    .next_bits  (plru_next),
    .victim_way (tree_victim)
  );

  always_comb begin
    state_d     = state_q;
    flush_set_d = flush_set_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    plru_d      = plru_q;
    tag_d       = tag_q;
    data_d      = data_q;
    read_data_d = read_data_q;
    rd_valid_d  = 1'b0;

    if (fire) begin
      case (req_op)
        OP_READ: begin
          rd_valid_d  = 1'b1;
          read_data_d = '0;
          if (any_hit) begin
            read_data_d = data_q[set][hit_way][word_idx];
            plru_d[set] = plru_next;
          end
        end
        OP_WRITE: begin
          if (any_hit) begin
            for (int b = 0; b < 4; b++) begin
              if (byte_en[b]) data_d[set][hit_way][word_idx][8*b +: 8] = write_data[8*b +: 8];
            end
            dirty_d[set][hit_way] = 1'b1;
            plru_d[set]           = plru_next;
          end
        end
        OP_FILL: begin
          data_d[set][way]  = fill_data;
          tag_d[set][way]   = tag;
          valid_d[set][way] = 1'b1;
          dirty_d[set][way] = 1'b0;
          plru_d[set]       = plru_next;
        end
        default: begin
          valid_d[set][way] = 1'b0;
          dirty_d[set][way] = 1'b0;
        end
      endcase
    end

    // Flush sweep runs after request effects so its clear of a set always wins.
    case (state_q)
      FL_IDLE: begin
        if (flush_start) begin
          state_d     = FL_FLUSH;
          flush_set_d = '0;
        end
      end
      default: begin
        valid_d[flush_set_q] = '0;
        dirty_d[flush_set_q] = '0;
        plru_d[flush_set_q]  = '0;
        if (flush_set_q == SetSize'(NUM_SETS - 1)) state_d = FL_IDLE;
        else flush_set_d = flush_set_q + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= FL_IDLE;
      flush_set_q <= '0;
      read_data_q <= '0;
      rd_valid_q  <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      flush_set_q <= flush_set_d;
      read_data_q <= read_data_d;
      rd_valid_q  <= rd_valid_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      plru_q      <= plru_d;
    end
  end

  // Tag and data arrays carry no reset so they can later map onto RAM macros.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assert property (@(posedge clk) disable iff (!rst) $onehot0(hits));

endmodule

// File: tb/tb_cache_array_plru.sv
// Self-checking bench for cache_array_plru (4 sets, 4 ways, 2 words per block):
// directed scenarios followed by randomized traffic against a behavioural model.
module tb_cache_array_plru;
  import cache_pkg::*;

  localparam int SETS = 4;
  localparam int WAYS = 4;
  localparam int WPB  = 2;
  localparam int TW   = 27;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    op;
  logic [1:0]    set;
  logic [TW-1:0] tag;
  logic [0:0]    offset;
  logic [1:0]    way;
  logic [3:0]    byte_en;
  logic [31:0]   write_data;
  logic [63:0]   fill_data;
  logic [3:0]    hits;
  logic [3:0]    valid_flags;
  logic [1:0]    victim_way;
  logic          victim_dirty;
  logic [TW-1:0] victim_tag;
  logic [63:0]   victim_data;
  logic [31:0]   read_data;
  logic          rd_valid;
  logic          flush_start;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Behavioural model: per-way state plus one "points to the less recent half" flag per tree node.
  bit            m_valid [SETS][WAYS];
  bit            m_dirty [SETS][WAYS];
  logic [TW-1:0] m_tag   [SETS][WAYS];
  logic [31:0]   m_data  [SETS][WAYS][WPB];
  bit            m_tree  [SETS][WAYS];

  cache_array_plru #(
    .ADDR_SIZE(32), .NUM_SETS(SETS), .NUM_WAYS(WAYS), .WORDS_PER_BLOCK(WPB)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .op(op),
    .set(set), .tag(tag), .offset(offset), .way(way), .byte_en(byte_en),
    .write_data(write_data), .fill_data(fill_data), .hits(hits), .valid_flags(valid_flags),
    .victim_way(victim_way), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
    .victim_data(victim_data), .read_data(read_data), .rd_valid(rd_valid),
    .flush_start(flush_start), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int modelHitWay(int s, logic [TW-1:0] t);
    for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  function automatic int modelVictim(int s);
    int node;
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
    node = 1;
    while (node < WAYS) node = 2 * node + int'(m_tree[s][node]);
    return node - WAYS;
  endfunction

  // Walk from the leaf to the root; every ancestor is pointed at the sibling subtree.
  function automatic void modelTouch(int s, int w);
    int leaf;
    leaf = w + WAYS;
    while (leaf > 1) begin
      m_tree[s][leaf / 2] = (leaf % 2 == 0);
      leaf = leaf / 2;
    end
  endfunction

  function automatic void modelClear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tree[s][w]  = 1'b0;
      end
  endfunction

  // Compares every combinational lookup output for whatever set/tag is currently driven.
  task automatic checkLookup(input int s, input logic [TW-1:0] t);
    logic [3:0] eh, ev;
    int vw;
    for (int w = 0; w < WAYS; w++) begin
      ev[w] = m_valid[s][w];
      eh[w] = m_valid[s][w] && (m_tag[s][w] == t);
    end
    vw = modelVictim(s);
    checkOutput("hits", hits, eh);
    checkOutput("valid_flags", valid_flags, ev);
    checkOutput("victim_way", victim_way, vw[1:0]);
    checkOutput("victim_dirty", victim_dirty, m_dirty[s][vw]);
    if (m_valid[s][vw]) begin
      checkOutput("victim_tag", victim_tag, m_tag[s][vw]);
      checkOutput("victim_data", victim_data, {m_data[s][vw][1], m_data[s][vw][0]});
    end
  endtask

  task automatic probe(input int s, input logic [TW-1:0] t);
    req_valid = 1'b0;
    set = 2'(s);
    tag = t;
    #1;
  endtask

  // Issues one request, checks lookup outputs before the edge and the registered result after it.
  task automatic applyStimulus(input logic [1:0] o, input int s, input logic [TW-1:0] t,
                               input int off, input int w, input logic [3:0] be,
                               input logic [31:0] wd, input logic [63:0] fd);
    int hw;
    logic [31:0] exp_rd;
    op = o; set = 2'(s); tag = t; offset = 1'(off); way = 2'(w);
    byte_en = be; write_data = wd; fill_data = fd; req_valid = 1'b1;
    #1;
    checkLookup(s, t);
    checkOutput("req_ready", req_ready, 1);
    hw = modelHitWay(s, t);
    exp_rd = (hw >= 0) ? m_data[s][hw][off] : 32'h0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    case (o)
      OP_READ:  if (hw >= 0) modelTouch(s, hw);
      OP_WRITE: if (hw >= 0) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) m_data[s][hw][off][8*b +: 8] = wd[8*b +: 8];
        m_dirty[s][hw] = 1'b1;
        modelTouch(s, hw);
      end
      OP_FILL: begin
        m_data[s][w][0] = fd[31:0];
        m_data[s][w][1] = fd[63:32];
        m_tag[s][w]     = t;
        m_valid[s][w]   = 1'b1;
        m_dirty[s][w]   = 1'b0;
        modelTouch(s, w);
      end
      default: begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    endcase
    if (o == OP_READ) begin
      checkOutput("rd_valid", rd_valid, 1);
      checkOutput("read_data", read_data, exp_rd);
    end else begin
      checkOutput("rd_valid_idle", rd_valid, 0);
    end
  endtask

  task automatic doReset();
    rst = 1'b0; req_valid = 1'b0; flush_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    modelClear();
  endtask

  // Raises flush together with a read: the flush must win and sweep exactly SETS cycles.
  task automatic doFlush();
    int cnt;
    op = OP_READ; set = 2'd0; req_valid = 1'b1; flush_start = 1'b1;
    #1;
    checkOutput("ready_at_flush_start", req_ready, 0);
    @(posedge clk);
    #1;
    flush_start = 1'b0; req_valid = 1'b0;
    checkOutput("flush_wins", rd_valid, 0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      checkOutput("ready_while_busy", req_ready, 0);
      cnt++;
      @(posedge clk);
      #1;
    end
    checkOutput("busy_cycles", cnt, SETS);
    modelClear();
    for (int s = 0; s < SETS; s++) begin
      probe(s, '0);
      checkOutput("flushed_valid", valid_flags, 0);
    end
  endtask

  initial begin
    logic [TW-1:0] pool [5];
    int s, off, w, hw, r;
    logic [TW-1:0] t;
    pool = '{27'h123, 27'h124, 27'h2A5, 27'h3FF0, 27'h7};
    rst = 1'b0; req_valid = 1'b0; flush_start = 1'b0; op = OP_READ; set = '0; tag = '0;
    offset = '0; way = '0; byte_en = '0; write_data = '0; fill_data = '0;

    // Reset state
    doReset();
    probe(0, 27'h123);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rd_valid", rd_valid, 0);
    checkOutput("reset_read_data", read_data, 0);
    checkOutput("reset_valid", valid_flags, 0);
    checkOutput("reset_ready", req_ready, 1);

    // Fill one way and look it up
    applyStimulus(OP_FILL, 0, 27'h123, 0, 1, 4'h0, 32'h0, {32'h1111_2222, 32'hCAFE_0001});
    probe(0, 27'h123);
    checkOutput("t1_hits", hits, 4'b0010);
    checkOutput("t1_valid", valid_flags, 4'b0010);
    checkOutput("t1_victim", victim_way, 0);

    // Read hit and read miss
    applyStimulus(OP_READ, 0, 27'h123, 0, 0, 4'h0, 32'h0, 64'h0);
    checkOutput("t2_read_hit", read_data, 32'hCAFE_0001);
    applyStimulus(OP_READ, 0, 27'h124, 0, 0, 4'h0, 32'h0, 64'h0);
    checkOutput("t2_miss_hits", hits, 0);
    checkOutput("t2_read_miss", read_data, 0);

    // Partial write, read-back, then make the dirty line the victim
    applyStimulus(OP_WRITE, 0, 27'h123, 0, 0, 4'b0011, 32'h0000_BEEF, 64'h0);
    applyStimulus(OP_READ, 0, 27'h123, 0, 0, 4'h0, 32'h0, 64'h0);
    checkOutput("t3_merged", read_data, 32'hCAFE_BEEF);
    applyStimulus(OP_FILL, 0, 27'h200, 0, 0, 4'h0, 32'h0, 64'hA0A0);
    applyStimulus(OP_FILL, 0, 27'h201, 0, 2, 4'h0, 32'h0, 64'hA2A2);
    applyStimulus(OP_FILL, 0, 27'h202, 0, 3, 4'h0, 32'h0, 64'hA3A3);
    probe(0, 27'h123);
    checkOutput("t3_victim_way", victim_way, 1);
    checkOutput("t3_victim_dirty", victim_dirty, 1);
    checkOutput("t3_victim_tag", victim_tag, 27'h123);

    // PLRU ordering in a full set. After touching way 2 then way 0 the root points right
    // and the right node (last touched by way 2) points at way 3.
    for (int i = 0; i < WAYS; i++)
      applyStimulus(OP_FILL, 1, 27'h300 + 27'(i), 0, i, 4'h0, 32'h0, 64'(i + 16));
    applyStimulus(OP_READ, 1, 27'h302, 0, 0, 4'h0, 32'h0, 64'h0);
    probe(1, 27'h302);
    checkOutput("t4_victim_after_way2", victim_way, 0);
    applyStimulus(OP_READ, 1, 27'h300, 1, 0, 4'h0, 32'h0, 64'h0);
    probe(1, 27'h300);
    checkOutput("t4_victim_after_way0", victim_way, 3);

    // Flush with every set holding valid lines
    applyStimulus(OP_FILL, 2, 27'h400, 0, 1, 4'h0, 32'h0, 64'h4444);
    applyStimulus(OP_FILL, 3, 27'h500, 0, 2, 4'h0, 32'h0, 64'h5555);
    doFlush();

    // Reset two cycles into a flush
    applyStimulus(OP_FILL, 2, 27'h600, 0, 0, 4'h0, 32'h0, 64'h6666);
    flush_start = 1'b1;
    @(posedge clk);
    #1;
    flush_start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t6_busy", busy, 0);
    rst = 1'b1;
    modelClear();
    for (int i = 0; i < SETS; i++) begin
      probe(i, 27'h600);
      checkOutput("t6_valid", valid_flags, 0);
    end
    applyStimulus(OP_FILL, 2, 27'h600, 0, 3, 4'h0, 32'h0, 64'h7777);

    // Randomized traffic over a small tag pool so hits, misses and evictions all occur
    for (int i = 0; i < 400; i++) begin
      s   = $urandom_range(0, SETS - 1);
      t   = pool[$urandom_range(0, 4)];
      off = $urandom_range(0, 1);
      r   = $urandom_range(0, 99);
      if (r < 2) begin
        doFlush();
      end else if (r < 32) begin
        applyStimulus(OP_READ, s, t, off, 0, 4'h0, 32'h0, 64'h0);
      end else if (r < 55) begin
        applyStimulus(OP_WRITE, s, t, off, 0, 4'($urandom_range(0, 15)), $urandom, 64'h0);
      end else if (r < 85) begin
        w  = ($urandom_range(0, 1) == 1) ? modelVictim(s) : $urandom_range(0, WAYS - 1);
        hw = modelHitWay(s, t);
        if (hw >= 0) w = hw;
        applyStimulus(OP_FILL, s, t, off, w, 4'h0, 32'h0, {$urandom, $urandom});
      end else begin
        applyStimulus(OP_INVAL, s, t, off, $urandom_range(0, WAYS - 1), 4'h0, 32'h0, 64'h0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
